// File: rtl/conv_x_stream_tx.sv
// conv_x_stream_tx
//
// Transmit-side driver for the x input stream of the conv layers. It holds one
// vector of X signed words, written through a simple load port while idle. On
// start it streams the vector in address order over a valid/ready handshake,
// repeated for a programmable number of frames back-to-back. It runs one word
// per cycle when the consumer is always ready.
//
// Optional build macro: CONV_TX_STALL_INJECT_EN
//   When defined, a 16-bit Galois LFSR adds random bubbles before new words are
//   presented. Data order and count do not change. When undefined, no LFSR is
//   built.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   ld_en    in   buffer write strobe (ignored while busy)
//   ld_addr  in   buffer write address
//   ld_data  in   signed word to store
//   frames   in   frame count, sampled on start (0 is treated as 1)
//   start    in   one-cycle request to begin transmission
//   busy     out  high from accepted start until the last handshake
//   done     out  one-cycle pulse after the final handshake
//   x_data   out  signed stream word
//   x_valid  out  stream word valid
//   x_ready  in   downstream ready
module conv_x_stream_tx #(
   parameter int          X         = 32,
   parameter int          W         = 16,
   parameter int          FW        = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ld_en,
   input  logic [$clog2(X)-1:0]   ld_addr,
   input  logic signed [W-1:0]    ld_data,
   input  logic [FW-1:0]          frames,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic signed [W-1:0]    x_data,
   output logic                   x_valid,
   input  logic                   x_ready
);

   localparam int AW = $clog2(X);

   typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, LAST} state_t;

   logic signed [W-1:0] mem [X];

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [FW-1:0]       frames_q, frames_d;
   logic [AW-1:0]       word_q, word_d;
   logic [FW-1:0]       frame_q, frame_d;
   logic                rd_en;
   logic                rd_vld_q, rd_vld_d;
   logic signed [W-1:0] rd_data_q;
   logic                q0_vld_q, q0_vld_d;
   logic signed [W-1:0] x_data_q, x_data_d;
   logic                q1_vld_q, q1_vld_d;
   logic signed [W-1:0] q1_data_q, q1_data_d;
   logic                x_valid_q, x_valid_d;

   logic                pop;
   logic                keep;
   logic [1:0]          occ;
   logic                credit_ok;
   logic                bubble;
   logic                h0_vld, h1_vld;
   logic signed [W-1:0] h0_data, h1_data;

`ifdef CONV_TX_STALL_INJECT_EN
   // Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (right-shift form).
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (busy_q) begin
         lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign bubble = lfsr_q[0];
`else
   // The seed only matters for stall injection; without it no bubble is ever added.
   assign bubble = 1'b0 && (LFSR_SEED != 16'h0000);
`endif

   assign pop = x_valid_q && x_ready;

   // The output word (q0) and the skid word (q1) form a two-entry queue. A new
   // read is issued only when, even if the consumer stalls next cycle, the read
   // data still fits into the queue.
   always_comb begin
      occ       = 2'(q0_vld_q) + 2'(q1_vld_q) + 2'(rd_vld_q);
      credit_ok = pop ? (occ != 2'd3) : (occ <= 2'd1);
   end

   // Control FSM and read address generation
   always_comb begin
      state_d  = state_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      frames_d = frames_q;
      word_d   = word_q;
      frame_d  = frame_q;
      rd_en    = 1'b0;

      case (state_q)
         IDLE: begin
            // A start that coincides with done is deliberately not accepted.
            if (start && !done_q) begin
               frames_d = (frames == '0) ? FW'(1) : frames;
               word_d   = '0;
               frame_d  = '0;
               busy_d   = 1'b1;
               state_d  = PREFETCH;
            end
         end
         PREFETCH: begin
            rd_en   = 1'b1;
            state_d = STREAM;
         end
         STREAM: begin
            rd_en = credit_ok;
         end
         LAST: begin
            if (pop && !q1_vld_q && !rd_vld_q) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // The read of address 0 for the next frame follows the read of X-1
      // directly, so frame boundaries add no bubble.
      if (rd_en) begin
         if (word_q == AW'(X - 1)) begin
            word_d  = '0;
            frame_d = frame_q + FW'(1);
            if (frame_q == frames_q - FW'(1)) begin
               state_d = LAST;
            end
         end else begin
            word_d = word_q + AW'(1);
         end
      end
   end

   // Output queue: remove the head on a transfer, then append any arriving read
   always_comb begin
      keep    = x_valid_q && !pop;
      h0_vld  = q0_vld_q;
      h0_data = x_data_q;
      h1_vld  = q1_vld_q;
      h1_data = q1_data_q;
      if (pop) begin
         h0_vld  = q1_vld_q;
         h0_data = q1_data_q;
         h1_vld  = 1'b0;
      end
      if (rd_vld_q) begin
         if (!h0_vld) begin
            h0_vld  = 1'b1;
            h0_data = rd_data_q;
         end else begin
            h1_vld  = 1'b1;
            h1_data = rd_data_q;
         end
      end
      q0_vld_d  = h0_vld;
      q1_vld_d  = h1_vld;
      q1_data_d = h1_data;
      x_data_d  = h0_vld ? h0_data : x_data_q;
      // A word already shown stays shown; a bubble only delays a newly presented word.
      x_valid_d = h0_vld && (keep || !bubble);
      rd_vld_d  = rd_en;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         frames_q  <= '0;
         word_q    <= '0;
         frame_q   <= '0;
         rd_vld_q  <= 1'b0;
         q0_vld_q  <= 1'b0;
         x_data_q  <= '0;
         q1_vld_q  <= 1'b0;
         q1_data_q <= '0;
         x_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         frames_q  <= frames_d;
         word_q    <= word_d;
         frame_q   <= frame_d;
         rd_vld_q  <= rd_vld_d;
         q0_vld_q  <= q0_vld_d;
         x_data_q  <= x_data_d;
         q1_vld_q  <= q1_vld_d;
         q1_data_q <= q1_data_d;
         x_valid_q <= x_valid_d;
      end
   end

   // Vector buffer: no reset, so contents survive a reset.
   always_ff @(posedge clk) begin
      if (ld_en && !busy_q) begin
         mem[ld_addr] <= ld_data;
      end
      if (rd_en) begin
         rd_data_q <= mem[word_q];
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign x_data  = x_data_q;
   assign x_valid = x_valid_q;

endmodule

// File: tb/tb_conv_x_stream_tx.sv
module tb_conv_x_stream_tx;

  logic               clk = 1'b0;
  logic               reset;
  logic               ld_en;
  logic [4:0]         ld_addr;
  logic signed [15:0] ld_data;
  logic [7:0]         frames;
  logic               start;
  logic               busy;
  logic               done;
  logic signed [15:0] x_data;
  logic               x_valid;
  logic               x_ready;

  logic signed [15:0] exp_mem [32];
  int errors = 0;
  int checks = 0;

  conv_x_stream_tx dut (
    .clk     (clk),
    .reset   (reset),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .frames  (frames),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .x_data  (x_data),
    .x_valid (x_valid),
    .x_ready (x_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_vector;
    for (int i = 0; i < 32; i++) begin
      ld_en      = 1'b1;
      ld_addr    = 5'(i);
      ld_data    = 16'(i * 3 - 40);
      exp_mem[i] = 16'(i * 3 - 40);
      tick;
    end
    ld_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    frames = 8'd1; start = 1'b0; x_ready = 1'b1;
    repeat (3) tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", x_valid); end
    checks++; if (x_data !== 16'sd0) begin errors++; $display("FAIL reset_data got=%0d exp=0", x_data); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_single_frame;
    int n, gaps, cyc;
    n = 0; gaps = 0; cyc = 0;
    frames = 8'd1; x_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    checks++; if (x_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL lat_edge0 got valid=%b busy=%b exp valid=0 busy=1", x_valid, busy); end
    tick;
    checks++; if (x_valid !== 1'b0) begin errors++; $display("FAIL lat_edge1 got=%b exp=0", x_valid); end
    tick;
    checks++; if (x_valid !== 1'b1) begin errors++; $display("FAIL lat_edge2 got=%b exp=1", x_valid); end
    while (n < 32 && cyc < 200) begin
      if (x_valid) begin
        checks++;
        if (x_data !== exp_mem[n]) begin errors++; $display("FAIL single_word%0d got=%0d exp=%0d", n, x_data, exp_mem[n]); end
        n++;
      end else gaps++;
      tick; cyc++;
    end
    checks++; if (n !== 32) begin errors++; $display("FAIL single_count got=%0d exp=32", n); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL single_gaps got=%0d exp=0", gaps); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || x_valid !== 1'b0) begin errors++; $display("FAIL single_end got done=%b busy=%b valid=%b exp 1 0 0", done, busy, x_valid); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_multi_frame(input int nf);
    int n, gaps, cyc, dn, total;
    total = 32 * nf; n = 0; gaps = 0; cyc = 0; dn = 0;
    frames = 8'(nf); x_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    while (n < total && cyc < total * 4 + 50) begin
      if (done) dn++;
      if (x_valid) begin
        checks++;
        if (x_data !== exp_mem[n % 32]) begin errors++; $display("FAIL multi%0d_word%0d got=%0d exp=%0d", nf, n, x_data, exp_mem[n % 32]); end
        n++;
      end else if (n > 0) gaps++;
      tick; cyc++;
    end
    checks++; if (n !== total) begin errors++; $display("FAIL multi%0d_count got=%0d exp=%0d", nf, n, total); end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL multi%0d_gaps got=%0d exp=0", nf, gaps); end
    checks++; if (dn !== 0) begin errors++; $display("FAIL multi%0d_early_done got=%0d exp=0", nf, dn); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || x_valid !== 1'b0) begin errors++; $display("FAIL multi%0d_end got done=%b busy=%b valid=%b exp 1 0 0", nf, done, busy, x_valid); end
    tick;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multi%0d_done_pulse got=%b exp=0", nf, done); end
  endtask

  task automatic test_backpressure;
    int n, cyc, hold;
    logic held, prev_stall;
    logic signed [15:0] prev_data;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    n = 0; cyc = 0; hold = 0; held = 1'b0; prev_stall = 1'b0; prev_data = '0;
    frames = 8'd2; x_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    while (n < 64 && cyc < 1000) begin
      if (n == 31 && !held) begin hold = 10; held = 1'b1; end
      if (hold > 0) begin x_ready = 1'b0; hold--; end
      else x_ready = pat[cyc % 4];
      if (prev_stall) begin
        checks++;
        if (x_valid !== 1'b1 || x_data !== prev_data) begin errors++; $display("FAIL bp_stable got valid=%b data=%0d exp valid=1 data=%0d", x_valid, x_data, prev_data); end
      end
      if (x_valid && x_ready) begin
        checks++;
        if (x_data !== exp_mem[n % 32]) begin errors++; $display("FAIL bp_word%0d got=%0d exp=%0d", n, x_data, exp_mem[n % 32]); end
        n++;
      end
      prev_stall = x_valid && !x_ready;
      prev_data  = x_data;
      tick; cyc++;
    end
    x_ready = 1'b1;
    checks++; if (n !== 64) begin errors++; $display("FAIL bp_count got=%0d exp=64", n); end
    checks++; if (done !== 1'b1 || x_valid !== 1'b0) begin errors++; $display("FAIL bp_end got done=%b valid=%b exp 1 0", done, x_valid); end
    tick;
  endtask

  task automatic test_load_while_busy;
    int n, cyc;
    logic inj;
    logic signed [15:0] got5;
    n = 0; cyc = 0; inj = 1'b0;
    frames = 8'd1; x_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    while (n < 32 && cyc < 200) begin
      ld_en = 1'b0; start = 1'b0;
      if (x_valid) begin
        checks++;
        if (x_data !== exp_mem[n]) begin errors++; $display("FAIL lwb_word%0d got=%0d exp=%0d", n, x_data, exp_mem[n]); end
        n++;
      end
      if (n == 2 && !inj) begin
        ld_en = 1'b1; ld_addr = 5'd5; ld_data = 16'sh7FFF; start = 1'b1; inj = 1'b1;
      end
      tick; cyc++;
    end
    ld_en = 1'b0;
    checks++; if (n !== 32 || done !== 1'b1) begin errors++; $display("FAIL lwb_end got n=%0d done=%b exp 32 1", n, done); end
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lwb_start_on_done got busy=%b exp=0", busy); end
    tick;
    checks++; if (busy !== 1'b0 || x_valid !== 1'b0) begin errors++; $display("FAIL lwb_idle got busy=%b valid=%b exp 0 0", busy, x_valid); end
    ld_en = 1'b1; ld_addr = 5'd5; ld_data = 16'sh7FFF;
    tick;
    ld_en = 1'b0;
    exp_mem[5] = 16'sh7FFF;
    n = 0; cyc = 0; got5 = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    while (n < 32 && cyc < 200) begin
      if (x_valid) begin
        if (n == 5) got5 = x_data;
        checks++;
        if (x_data !== exp_mem[n]) begin errors++; $display("FAIL lwb2_word%0d got=%0d exp=%0d", n, x_data, exp_mem[n]); end
        n++;
      end
      tick; cyc++;
    end
    checks++; if (got5 !== 16'sh7FFF) begin errors++; $display("FAIL lwb_new_word5 got=%0d exp=32767", got5); end
    tick;
  endtask

  task automatic test_reset_mid;
    int n, cyc, gaps;
    n = 0; cyc = 0; gaps = 0;
    frames = 8'd1; x_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    while (n < 12 && cyc < 200) begin
      if (x_valid) n++;
      tick; cyc++;
    end
    checks++; if (x_valid !== 1'b1 || x_data !== exp_mem[12]) begin errors++; $display("FAIL rst_pre got valid=%b data=%0d exp 1 %0d", x_valid, x_data, exp_mem[12]); end
    reset = 1'b1;
    #1;
    checks++; if (x_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async got valid=%b busy=%b exp 0 0", x_valid, busy); end
    tick; tick;
    reset = 1'b0;
    tick;
    n = 0; cyc = 0;
    frames = 8'd0; start = 1'b1;
    tick;
    start = 1'b0;
    while (n < 32 && cyc < 200) begin
      if (x_valid) begin
        checks++;
        if (x_data !== exp_mem[n]) begin errors++; $display("FAIL rst_word%0d got=%0d exp=%0d", n, x_data, exp_mem[n]); end
        n++;
      end else if (n > 0) gaps++;
      tick; cyc++;
    end
    checks++; if (n !== 32 || gaps !== 0) begin errors++; $display("FAIL rst_frames0 got n=%0d gaps=%0d exp 32 0", n, gaps); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_end got done=%b busy=%b exp 1 0", done, busy); end
    tick;
  endtask

  task automatic test_stall;
    int n, cyc, gaps;
    n = 0; cyc = 0; gaps = 0;
    frames = 8'd4; x_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    while (n < 128 && cyc < 2000) begin
      if (x_valid) begin
        checks++;
        if (x_data !== exp_mem[n % 32]) begin errors++; $display("FAIL stall_word%0d got=%0d exp=%0d", n, x_data, exp_mem[n % 32]); end
        n++;
      end else if (n > 0) gaps++;
      tick; cyc++;
    end
    checks++; if (n !== 128) begin errors++; $display("FAIL stall_count got=%0d exp=128", n); end
`ifdef CONV_TX_STALL_INJECT_EN
    checks++; if (gaps < 1) begin errors++; $display("FAIL stall_bubbles got=%0d exp>=1", gaps); end
`else
    checks++; if (gaps !== 0) begin errors++; $display("FAIL stall_bubbles got=%0d exp=0", gaps); end
`endif
    checks++; if (done !== 1'b1 || x_valid !== 1'b0) begin errors++; $display("FAIL stall_end got done=%b valid=%b exp 1 0", done, x_valid); end
    tick;
  endtask

  initial begin
    test_reset;
    load_vector;
    test_single_frame;
    test_multi_frame(3);
    test_backpressure;
    test_load_while_busy;
    test_reset_mid;
    test_stall;
    test_multi_frame(255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_x_stream_tx.md
Name: conv_x_stream_tx

Overview:
- Transmit-side driver for the x input stream of the conv layers (conv_32_6_16_1 and siblings).
- Holds one input vector of X signed words, loaded through a simple write port.
- On start, streams the vector in address order over an x_data/x_valid/x_ready handshake, repeated a programmable number of frames back-to-back.
- Sits between the test/host loader and the conv layer's x port.

Parameters:
- X, 32, vector length in words (power of two not required; >= 2)
- W, 16, data word width in bits
- FW, 8, width of the frame-count input
- LFSR_SEED, 16'hACE1, nonzero seed for the optional stall generator

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- ld_en  in  1  write strobe for the vector buffer
- ld_addr  in  $clog2(X)  buffer write address
- ld_data  in  W  signed word to store
- frames  in  FW  number of frames to send; 0 treated as 1; sampled on start
- start  in  1  one-cycle request to begin transmission
- busy  out  1  high from accepted start until last handshake
- done  out  1  one-cycle pulse the cycle after the final handshake
- x_data  out  W  signed stream word
- x_valid  out  1  stream word valid
- x_ready  in  1  downstream ready

Behaviour:
- Reset (async): busy=0, done=0, x_valid=0, x_data=0, all counters 0, FSM to IDLE. Buffer array is not reset; contents are retained.
- Buffer: X x W, synchronous write when ld_en && !busy; ld_en while busy is ignored. Synchronous 1-cycle read.
- FSM states:
  - IDLE: wait for start. On start (busy=0): latch frames (0->1), word counter=0, frame counter=0, go to PREFETCH, busy=1.
  - PREFETCH: issue read of address 0. Go to STREAM.
  - STREAM: output stage plus one-entry skid register.
  - LAST: draining final word.
- Latency: x_valid rises on the 2nd rising edge after the edge that samples start (start sampled at edge 0, x_valid=1 after edge 2).
- Handshake: a transfer occurs on an edge where x_valid && x_ready.
  - Once x_valid=1, x_valid and x_data hold stable until the transfer.
  - x_valid never depends combinationally on x_ready.
- Throughput: with x_ready held high, exactly one word per cycle with no bubbles, including across frame boundaries.
- Order: words addr 0..X-1, then 0..X-1 again for each remaining frame. Total transfers = X * max(frames,1).
- Wrap: word counter wraps X-1 -> 0 and increments the frame counter. The read for address 0 of the next frame is prefetched during the last word of the current frame.
- Completion: on the final transfer, x_valid=0 from the next cycle, busy=0 and done=1 for exactly that one cycle, FSM to IDLE.
- start while busy: ignored.
- start coincident with done: ignored; start must be re-asserted when busy=0.
- x_ready low for any duration: no word lost or duplicated. The skid entry absorbs the in-flight read.
- Reset mid-stream: x_valid drops immediately (asynchronous). After release, behaves as power-up, with buffer contents intact.
- Arithmetic: counters are unsigned. The frame compare uses the latched FW-bit value; 255 frames must work.

Optional Feature:
- Macro: CONV_TX_STALL_INJECT_EN.
- Defined:
  - Add a 16-bit Galois LFSR (taps 16,14,13,11), seeded with LFSR_SEED on reset, stepping every cycle while busy.
  - When LFSR bit0=1, the block may not raise x_valid from 0 to 1 that cycle (bubble insertion).
  - An already-asserted x_valid is never withdrawn.
  - Data order and count are unchanged.
- Not defined: no LFSR logic; x_valid rises whenever data is available.

Test Plan:
- Load addr i with i*3-40 for i=0..31, frames=1, x_ready=1, pulse start -> x_valid high 2 cycles later. 32 consecutive transfers: -40,-37,...,53. Then done pulse, busy=0, x_valid=0.
- Same load, frames=3, x_ready=1 -> 96 gap-free transfers with the sequence repeated 3 times, single done at the end.
- frames=2; x_ready toggles 1,0,0,1 repeating, plus a 10-cycle low hold at word 31 -> x_data stable whenever valid&&!ready. Exactly 64 transfers in order, no duplicates.
- Assert ld_en with addr 5, data 16'h7FFF, and a second start while busy -> transmitted word 5 keeps its old value, second start ignored. After done, a new start sends 16'h7FFF at word 5.
- Assert reset mid-frame at word 12 -> x_valid/busy low the same cycle. After release, start with frames=0 -> 32 transfers (treated as 1 frame) with the original buffer contents.
- Build with CONV_TX_STALL_INJECT_EN, x_ready=1, frames=4 -> 128 correct ordered transfers, at least one bubble observed, x_valid never falls without a transfer.
